// File: rtl/fifo_rd_packer_if.sv
// fifo_rd_packer_if: bundles the FIFO read port, flush request and the
// packed valid/ready output stream of fifo_rd_packer.
//   rdata/rempty/rinc   : FIFO first-word-fall-through read port
//   flush               : single-cycle partial-word emit request
//   out_data/out_keep   : packed word and per-lane keep mask
//   out_valid/out_ready : output stream handshake
// master = packer side, slave = FIFO/sink side.
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
);
    logic [DSIZE-1:0]       rdata;
    logic                   rempty;
    logic                   rinc;
    logic                   flush;
    logic [RATIO*DSIZE-1:0] out_data;
    logic [RATIO-1:0]       out_keep;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        input  rdata, rempty, flush, out_ready,
        output rinc, out_data, out_keep, out_valid
    );

    modport slave (
        output rdata, rempty, flush, out_ready,
        input  rinc, out_data, out_keep, out_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops DSIZE-bit words from a FWFT FIFO and packs RATIO of
// them (lane 0 = oldest) into one word on a valid/ready stream.
// Ports: rclk, rrst (async, active-high), bus (fifo_rd_packer_if.master).
// Partial words leave on flush with out_keep marking the filled lanes.
// Optional macro FIFO_PACK_TIMEOUT_EN adds an idle-timeout auto-flush.
module fifo_rd_packer #(
    parameter int DSIZE   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              rclk,
    input  logic              rrst,
    fifo_rd_packer_if.master  bus
);
    localparam int CW = $clog2(RATIO + 1);
    localparam logic [CW-1:0] FULL = CW'(RATIO);

    logic [RATIO-1:0][DSIZE-1:0] r_acc;
    logic [CW-1:0]               r_cnt;
    logic                        r_fpend;
    logic                        r_ovalid;
    logic [RATIO*DSIZE-1:0]      r_odata;
    logic [RATIO-1:0]            r_okeep;

    logic                        w_free;
    logic                        w_rd;
    logic                        w_tmo;
    logic                        w_flush;
    logic [RATIO-1:0][DSIZE-1:0] w_acc_n;
    logic [CW-1:0]               w_lanes;
    logic [CW-1:0]               w_cnt_n;
    logic                        w_fpend_n;
    logic                        w_emit;
    logic [RATIO-1:0]            w_keep;
    logic [RATIO*DSIZE-1:0]      w_data;

    assign w_free  = !r_ovalid | bus.out_ready;
    assign w_rd    = !rrst & !bus.rempty & !r_fpend & (r_cnt < FULL);
    assign w_flush = bus.flush | w_tmo;

    assign bus.rinc      = w_rd;
    assign bus.out_data  = r_odata;
    assign bus.out_keep  = r_okeep;
    assign bus.out_valid = r_ovalid;

    // Lane image after this cycle's read; the emitted word is always
    // built from it, so a same-cycle read is included in any emission.
    always_comb begin
        w_acc_n = r_acc;
        for (int i = 0; i < RATIO; i++) begin
            if (w_rd && r_cnt == CW'(i)) begin
                w_acc_n[i] = bus.rdata;
            end
        end
    end

    assign w_lanes = r_cnt + CW'(w_rd);

    always_comb begin
        w_keep = '0;
        w_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            w_keep[i] = CW'(i) < w_lanes;
            if (w_keep[i]) begin
                w_data[i*DSIZE +: DSIZE] = w_acc_n[i];
            end
        end
    end

    // Pending flush wins, then a full word; a flush arriving with either
    // is absorbed since the current lanes already go out.
    always_comb begin
        w_emit    = 1'b0;
        w_cnt_n   = w_lanes;
        w_fpend_n = r_fpend;
        if (r_fpend) begin
            if (w_free) begin
                w_emit    = 1'b1;
                w_cnt_n   = '0;
                w_fpend_n = 1'b0;
            end
        end else if (w_lanes == FULL) begin
            if (w_free) begin
                w_emit  = 1'b1;
                w_cnt_n = '0;
            end
        end else if (w_flush && w_lanes != '0) begin
            if (w_free) begin
                w_emit  = 1'b1;
                w_cnt_n = '0;
            end else begin
                w_fpend_n = 1'b1;
            end
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_fpend  <= 1'b0;
            r_ovalid <= 1'b0;
            r_odata  <= '0;
            r_okeep  <= '0;
        end else begin
            r_acc   <= w_emit ? '0 : w_acc_n;
            r_cnt   <= w_cnt_n;
            r_fpend <= w_fpend_n;
            if (w_emit) begin
                r_ovalid <= 1'b1;
                r_odata  <= w_data;
                r_okeep  <= w_keep;
            end else if (bus.out_ready) begin
                r_ovalid <= 1'b0;
            end
        end
    end

`ifdef FIFO_PACK_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);

    logic [IW-1:0] r_idle;
    logic          w_idle;

    assign w_idle = (r_cnt != '0) & !w_rd & !bus.flush & !r_fpend;
    // Fire on the cycle the count would reach TIMEOUT so the word
    // appears TIMEOUT cycles after the last pop.
    assign w_tmo  = w_idle & (r_idle == IW'(TIMEOUT - 1));

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_idle <= '0;
        end else if (w_rd | w_emit | w_tmo) begin
            r_idle <= '0;
        end else if (w_idle) begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif
endmodule
